// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: ALUOp field, 4-bit control codes, FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    CTL_AND  = 4'd0,
    CTL_OR   = 4'd1,
    CTL_ADD  = 4'd2,
    CTL_XOR  = 4'd3,
    CTL_SLL  = 4'd4,
    CTL_SRL  = 4'd5,
    CTL_SUB  = 4'd6,
    CTL_SLT  = 4'd7,
    CTL_SLTU = 4'd8,
    CTL_SRA  = 4'd9,
    CTL_MUL  = 4'd10,
    CTL_ILL  = 4'd15
  } ctl_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALUOp/funct3/funct7 -> 4-bit ALU control code; no latency, no handshake.
module alu_ctl_decode
  import alu_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output ctl_e       ctl
);

  always_comb begin
    ctl = CTL_ILL;
    case (alu_op_e'(alu_op))
      ALUOP_ADD: ctl = CTL_ADD;
      ALUOP_SUB: ctl = CTL_SUB;
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  ctl = CTL_ADD;
            3'b001:  ctl = CTL_SLL;
            3'b010:  ctl = CTL_SLT;
            3'b011:  ctl = CTL_SLTU;
            3'b100:  ctl = CTL_XOR;
            3'b101:  ctl = CTL_SRL;
            3'b110:  ctl = CTL_OR;
            default: ctl = CTL_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000)      ctl = CTL_SUB;
          else if (funct3 == 3'b101) ctl = CTL_SRA;
        end else if (MUL_EN && funct7 == F7_MULD && funct3 == 3'b000) begin
          ctl = CTL_MUL;
        end
      end
      default: begin
        // Immediates occupy funct7 except for shifts, so only shifts look at it.
        case (funct3)
          3'b000:  ctl = CTL_ADD;
          3'b001:  ctl = (funct7 == F7_BASE) ? CTL_SLL : CTL_ILL;
          3'b010:  ctl = CTL_SLT;
          3'b011:  ctl = CTL_SLTU;
          3'b100:  ctl = CTL_XOR;
          3'b101:  ctl = funct7[5] ? CTL_SRA : CTL_SRL;
          3'b110:  ctl = CTL_OR;
          default: ctl = CTL_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU behind valid/ready: 1-cycle ops, XLEN+1-cycle iterative MUL.
// Result is held while out_ready is low; in_ready drops during MUL and while stalled.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1,
  parameter int TAG_W  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] tag_out
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_e          state;
  ctl_e            ctl;
  logic            accept;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] mul_sum;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [CW-1:0]   cnt;

  alu_ctl_decode #(.MUL_EN(MUL_EN)) u_decode (
    .alu_op (alu_op),
    .funct3 (funct3),
    .funct7 (funct7),
    .ctl    (ctl)
  );

  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign shamt    = op_b[SHW-1:0];
  assign mul_sum  = acc + (mplier[0] ? mcand : '0);

  always_comb begin
    alu_res = '0;
    case (ctl)
      CTL_AND:  alu_res = op_a & op_b;
      CTL_OR:   alu_res = op_a | op_b;
      CTL_ADD:  alu_res = op_a + op_b;
      CTL_XOR:  alu_res = op_a ^ op_b;
      CTL_SLL:  alu_res = op_a << shamt;
      CTL_SRL:  alu_res = op_a >> shamt;
      CTL_SUB:  alu_res = op_a - op_b;
      CTL_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      CTL_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      CTL_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      tag_out   <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= mul_sum;
            zero      <= (mul_sum == '0);
            illegal   <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            tag_out <= tag_in;
            if (ctl == CTL_MUL) begin
              state     <= S_MUL;
              out_valid <= 1'b0;
              acc       <= '0;
              mcand     <= op_a;
              mplier    <= op_b;
              cnt       <= '0;
            end else begin
              // Illegal decodes fall through alu_res's default, giving result 0.
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              zero      <= (alu_res == '0);
              illegal   <= (ctl == CTL_ILL);
            end
          end else if (state == S_DONE && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: one MUL-enabled and one MUL-disabled instance share stimulus.
module tb_alu_exec_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  tag_in;
  logic        out_ready;

  logic        in_ready, out_valid, zero, illegal;
  logic [31:0] result;
  logic [3:0]  tag_out;
  logic        nm_in_ready, nm_out_valid, nm_zero, nm_illegal;
  logic [31:0] nm_result;
  logic [3:0]  nm_tag_out;

  int n_assert = 0;
  int n_fail   = 0;
  int low;

  always #5 clock = ~clock;

  alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1), .TAG_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .tag_out(tag_out)
  );

  alu_exec_unit #(.XLEN(32), .MUL_EN(1'b0), .TAG_W(4)) dut_nm (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(nm_in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op_a(op_a), .op_b(op_b),
    .tag_in(tag_in), .out_valid(nm_out_valid), .out_ready(out_ready), .result(nm_result),
    .zero(nm_zero), .illegal(nm_illegal), .tag_out(nm_tag_out)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    in_valid = 1'b1;
    alu_op   = op;
    funct3   = f3;
    funct7   = f7;
    op_a     = a;
    op_b     = b;
    tag_in   = t;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    drive(op, f3, f7, a, b, t);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    in_valid  = 1'b0;
    alu_op    = 2'b00;
    funct3    = 3'b000;
    funct7    = 7'h00;
    op_a      = '0;
    op_b      = '0;
    tag_in    = '0;
    out_ready = 1'b1;
    reset_n   = 1'b0;
    step();
    step();

    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    chkw("rst_result", result, 32'h0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chkw("rst_tag", 32'(tag_out), 32'h0);

    reset_n = 1'b1;
    step();

    send(2'b10, 3'b000, 7'h00, 32'd5, 32'd7, 4'd1);
    chk1("add_vld", out_valid, 1'b1);
    chkw("add_res", result, 32'd12);
    chk1("add_zero", zero, 1'b0);
    chk1("add_ill", illegal, 1'b0);
    chkw("add_tag", 32'(tag_out), 32'd1);

    send(2'b01, 3'b000, 7'h00, 32'h1234, 32'h1234, 4'd2);
    chkw("sub_res", result, 32'h0);
    chk1("sub_zero", zero, 1'b1);
    chkw("sub_tag", 32'(tag_out), 32'd2);

    send(2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 4'd3);
    chkw("sra_res", result, 32'hF800_0000);

    send(2'b11, 3'b000, 7'h20, 32'd1, 32'd1, 4'd4);
    chkw("addi_f7_res", result, 32'd2);

    send(2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'd5);
    chkw("slt_res", result, 32'd1);

    send(2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 4'd6);
    chkw("sltu_res", result, 32'd0);
    chk1("sltu_zero", zero, 1'b1);

    send(2'b11, 3'b001, 7'h00, 32'd1, 32'h21, 4'd7);
    chkw("slli_mask_res", result, 32'd2);

    send(2'b11, 3'b101, 7'h20, 32'hF000_0000, 32'd4, 4'd8);
    chkw("srai_res", result, 32'hFF00_0000);

    send(2'b11, 3'b101, 7'h00, 32'hF000_0000, 32'd4, 4'd9);
    chkw("srli_res", result, 32'h0F00_0000);

    send(2'b10, 3'b001, 7'h01, 32'd5, 32'd7, 4'd10);
    chk1("ill_r_vld", out_valid, 1'b1);
    chk1("ill_r_flag", illegal, 1'b1);
    chkw("ill_r_res", result, 32'h0);
    chk1("ill_r_zero", zero, 1'b1);

    send(2'b11, 3'b001, 7'h20, 32'd5, 32'd1, 4'd11);
    chk1("ill_slli_flag", illegal, 1'b1);

    step();
    chk1("idle_vld", out_valid, 1'b0);
    chk1("idle_rdy", in_ready, 1'b1);

    // MUL: busy for 32 cycles while garbage requests are offered and must be ignored.
    send(2'b10, 3'b000, 7'h01, 32'hFFFF_FFFF, 32'd3, 4'd5);
    chk1("mul_busy_vld", out_valid, 1'b0);
    chk1("nm_vld", nm_out_valid, 1'b1);
    chk1("nm_ill", nm_illegal, 1'b1);
    chkw("nm_res", nm_result, 32'h0);
    chk1("nm_zero", nm_zero, 1'b1);
    chkw("nm_tag", 32'(nm_tag_out), 32'd5);
    chk1("nm_rdy", nm_in_ready, 1'b1);

    low = 0;
    drive(2'b00, 3'b000, 7'h00, 32'd9, 32'd9, 4'd7);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) in_valid = 1'b0;
      if (!in_ready && !out_valid) low++;
      step();
    end
    chkw("mul_busy_cycles", 32'(low), 32'd32);
    chk1("mul_vld", out_valid, 1'b1);
    chkw("mul_res", result, 32'hFFFF_FFFD);
    chkw("mul_tag", 32'(tag_out), 32'd5);
    chk1("mul_ill", illegal, 1'b0);
    chk1("mul_zero", zero, 1'b0);

    step();
    chk1("mul_drain_vld", out_valid, 1'b0);

    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 3'b000, 7'h00, 32'(i), 32'd100, 4'(8 + i));
      step();
      chk1("stream_vld", out_valid, 1'b1);
      chkw("stream_res", result, 32'(100 + i));
      chkw("stream_tag", 32'(tag_out), 32'(8 + i));
    end

    drive(2'b00, 3'b000, 7'h00, 32'd50, 32'd50, 4'd13);
    out_ready = 1'b0;
    #1;
    chk1("stall_rdy", in_ready, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk1("stall_vld", out_valid, 1'b1);
      chkw("stall_res", result, 32'd103);
      chkw("stall_tag", 32'(tag_out), 32'd11);
      chk1("stall_rdy_hold", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    chk1("unstall_rdy", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    chkw("unstall_res", result, 32'd100);
    chkw("unstall_tag", 32'(tag_out), 32'd13);
    step();
    chk1("unstall_idle_vld", out_valid, 1'b0);

    // Reset asserted partway through a MUL.
    send(2'b10, 3'b000, 7'h01, 32'd7, 32'd6, 4'd3);
    repeat (10) step();
    chk1("mid_mul_rdy", in_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    chk1("arst_vld", out_valid, 1'b0);
    chk1("arst_rdy", in_ready, 1'b1);
    chkw("arst_res", result, 32'h0);
    chkw("arst_tag", 32'(tag_out), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    send(2'b00, 3'b000, 7'h00, 32'd20, 32'd22, 4'd4);
    chk1("post_rst_vld", out_valid, 1'b1);
    chkw("post_rst_res", result, 32'd42);
    chkw("post_rst_tag", 32'(tag_out), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
